alu_pipe_n: RTL and testbench
=============================

// Module: alu_pipe_n
// PURPOSE
//   Parametrised, registered successor to the 4-bit combinational ALU.
//   WIDTH-bit datapath behind a valid/ready handshake on input and output.
//   Adds signed-overflow and zero flags, shift ops and a multi-cycle
//   shift-add multiply. Sits between a sequencer/register file and writeback.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>= 2)
// PORTS
//   clk        in   1      rising-edge clock, single clock domain
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand/op presented
//   in_ready   out  1      block can accept; transfer when in_valid && in_ready
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry/shift-in
//   op         in   3      operation select (see BEHAVIOUR)
//   out_valid  out  1      result registers hold an unconsumed result
//   out_ready  in   1      consumer takes result when out_valid && out_ready
//   f          out  WIDTH  result
//   cout       out  1      carry-out / shifted-out bit / MUL high-half nonzero
//   zero       out  1      f == 0
//   ovf        out  1      signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//   Reset (rst_n=0, async): f, cout, zero, ovf, out_valid = 0; FSM -> IDLE;
//     MUL counter and partial product cleared. Reset mid-MUL discards the op.
//   in_ready = (state==IDLE) && (!out_valid || out_ready), combinational.
//     Reads 1 immediately after reset release.
//   op codes (all 8 are legal):
//     000 ADD  {cout,f} = a + b + cin
//     001 SUB  {cout,f} = a + ~b + cin  (cin=1 -> true a-b; cout=1 = no borrow)
//     010 AND  f = a & b
//     011 OR   f = a | b
//     100 XOR  f = a ^ b               (cout=0 for 010..100)
//     101 SHL  f = {a[W-2:0],cin}, cout = a[W-1]
//     110 SHR  f = {cin,a[W-1:1]}, cout = a[0]
//     111 MUL  unsigned; f = P[W-1:0], cout = |P[2W-1:W]
//   ovf: ADD/SUB = carry into MSB XOR carry out of MSB; 0 for all other ops.
//   zero is computed on the registered f, for every op.
//   FSM: IDLE, BUSY.
//     IDLE, accept of ops 000-110: result and flags are registered on the
//       accepting edge; out_valid=1 in the next cycle (latency 1).
//       FSM stays in IDLE.
//     IDLE, accept of MUL: latch a, b; clear the accumulator; set count=0;
//       go to BUSY.
//     BUSY: one shift-add step per edge, count increments. The step with
//       count==WIDTH-1 writes f/cout/zero/ovf, sets out_valid, returns to
//       IDLE. out_valid rises exactly WIDTH cycles after the accept edge.
//       in_ready=0 throughout BUSY. in_valid is ignored in BUSY.
//   Output hold: while out_valid && !out_ready, f and all flags are stable
//     and in_ready=0.
//   out_valid clears on consume unless a new result loads on the same edge.
//   Simultaneous consume + accept (out_valid && out_ready && in_valid
//     && IDLE): the new single-cycle result replaces the old one on the
//     same edge, with out_valid kept at 1. This gives one result per cycle.
//   Arithmetic is modulo 2^WIDTH. MUL product is 2*WIDTH bits internally.
// TESTING (bench at WIDTH=4)
//   1 ADD a=1111 b=0001 cin=0 -> next cycle f=0000 cout=1 zero=1 ovf=0 out_valid=1.
//   2 ADD a=0111 b=0001 cin=0 -> f=1000 ovf=1.
//     SUB a=0101 b=0011 cin=1 -> f=0010 cout=1 ovf=0.
//   3 SHL a=1001 cin=1 -> f=0011 cout=1.
//     Back-to-back: SHR a=1001 cin=0 -> f=0100 cout=1.
//     With out_ready=1, one result per cycle.
//   4 MUL a=1111 b=1111 -> in_ready=0 for 4 cycles; out_valid 4 cycles after
//     accept; f=0001 cout=1. MUL a=0011 b=0010 -> f=0110 cout=0.
//   5 Hold out_ready=0 after an AND result: f/flags stable, in_ready=0,
//     in_valid ignored. Raise out_ready -> next op accepted same edge.
//   6 Assert rst_n=0 on MUL cycle 2 -> out_valid=0, f=0 immediately, no result.
//     After release, in_ready=1 and ADD 0010+0011 -> f=0101.

Source files
------------

// File: rtl/alu_pipe_n.sv
// -----------------------------------------------------------------------------
// alu_pipe_n
//   Registered WIDTH-bit ALU behind valid/ready handshakes on both sides.
//   Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR) produce a result one
//   cycle after the accepting edge. MUL is an unsigned shift-add multiply that
//   takes WIDTH cycles in the BUSY state before its result is presented.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/op presented by the producer
//   in_ready   block can accept (IDLE and output slot free or being consumed)
//   a, b       operands, WIDTH bits
//   cin        carry-in / shift-in bit
//   op         operation select (000 ADD .. 111 MUL)
//   out_valid  result registers hold an unconsumed result
//   out_ready  consumer takes the result when out_valid && out_ready
//   f          result, WIDTH bits
//   cout       carry-out / shifted-out bit / MUL high half nonzero
//   zero       f == 0
//   ovf        signed overflow, ADD/SUB only
// -----------------------------------------------------------------------------
module alu_pipe_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Multiplier state: multiplicand shifts left, multiplier shifts right,
  // so bit 0 of r_mplier always selects whether to add r_mcand this step.
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Result registers
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;
  logic             r_out_valid;

  // Single-cycle ALU result
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_f;
  logic             w_alu_c;
  logic             w_alu_v;

  logic w_fire;
  logic w_load_alu;
  logic w_mul_start;
  logic w_mul_done;

  assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

  assign w_fire      = in_valid && in_ready;
  assign w_load_alu  = w_fire && (op != OP_MUL);
  assign w_mul_start = w_fire && (op == OP_MUL);
  assign w_mul_done  = (r_state == ST_BUSY) && (r_cnt == CNT_LAST);

  // Combinational single-cycle ALU; SUB reuses the adder with b inverted.
  always_comb begin
    w_alu_f = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    if (op == OP_SUB) begin
      w_b_eff = ~b;
    end else begin
      w_b_eff = b;
    end
    w_sum = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};
    case (op)
      OP_ADD, OP_SUB: begin
        w_alu_f = w_sum[WIDTH-1:0];
        w_alu_c = w_sum[WIDTH];
        // Same-sign operands producing a different-sign result is exactly
        // carry-into-MSB XOR carry-out-of-MSB.
        w_alu_v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_alu_f = a & b;
      OP_OR:  w_alu_f = a | b;
      OP_XOR: w_alu_f = a ^ b;
      OP_SHL: begin
        w_alu_f = {a[WIDTH-2:0], cin};
        w_alu_c = a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_f = {cin, a[WIDTH-1:1]};
        w_alu_c = a[0];
      end
      default: begin
        w_alu_f = '0;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
      end
    endcase
  end

  // One shift-add step of the multiplier.
  always_comb begin
    if (r_mplier[0]) begin
      w_acc_nxt = r_acc + r_mcand;
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  // Next-state logic for the IDLE/BUSY controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mul_start) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_mul_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Multiplier operand/accumulator registers; a reset mid-MUL discards the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end else begin
      r_acc    <= r_acc;
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_cnt    <= r_cnt;
    end
  end

  // Result/flag registers and out_valid. A new result loading on a consume
  // edge keeps out_valid high, giving one result per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f         <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load_alu) begin
      r_f         <= w_alu_f;
      r_cout      <= w_alu_c;
      r_zero      <= (w_alu_f == {WIDTH{1'b0}});
      r_ovf       <= w_alu_v;
      r_out_valid <= 1'b1;
    end else if (w_mul_done) begin
      r_f         <= w_acc_nxt[WIDTH-1:0];
      r_cout      <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      r_zero      <= (w_acc_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

endmodule

// File: tb/tb_alu_pipe_n.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_n
//   Scoreboard bench for alu_pipe_n at WIDTH=4. The driver pushes the expected
//   result of every accepted op (from an integer reference model); a monitor
//   pops and compares whenever a result is consumed. Directed sections cover
//   latency, throughput, MUL timing, output hold and reset mid-MUL.
// -----------------------------------------------------------------------------
module tb_alu_pipe_n;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [2:0]   op = 3'b000;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         zero;
  logic         ovf;

  logic rand_en = 1'b0;
  logic rand_bit = 1'b0;
  logic force_rdy = 1'b1;
  assign out_ready = rand_en ? rand_bit : force_rdy;

  int n_checks = 0;
  int n_fail = 0;
  longint cyc = 0;
  longint last_acc = 0;
  longint prev_acc = 0;

  typedef struct packed {
    logic [W-1:0] f;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sbq[$];

  alu_pipe_n #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .cout(cout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input int o, input int x, input int y, input int ci);
    int m;
    int h;
    int s;
    int sx;
    int sy;
    int sr;
    exp_t e;
    m = 1 << W;
    h = m / 2;
    s = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    case (o)
      0: begin
        s = x + y + ci;
        e.c = (s >= m);
        sr = sx + sy + ci;
        e.v = (sr >= h) || (sr < -h);
      end
      1: begin
        s = x + (m - 1 - y) + ci;
        e.c = (s >= m);
        sr = sx + (-sy - 1) + ci;
        e.v = (sr >= h) || (sr < -h);
      end
      2: s = x & y;
      3: s = x | y;
      4: s = x ^ y;
      5: begin
        s = x * 2 + ci;
        e.c = (x >= h);
      end
      6: begin
        s = x / 2 + ci * h;
        e.c = (x % 2) != 0;
      end
      default: begin
        s = x * y;
        e.c = (s >= m);
      end
    endcase
    s = s % m;
    e.f = W'(s);
    e.z = (s == 0);
    return e;
  endfunction

  // Present one op, wait (bounded) for acceptance, push its expected result.
  task automatic issue(input int o, input int x, input int y, input int ci, input bit push);
    int waited;
    waited = 0;
    op = 3'(o);
    a = W'(x);
    b = W'(y);
    cin = 1'(ci);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      prev_acc = last_acc;
      last_acc = cyc;
      if (push) sbq.push_back(model(o, x, y, ci));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every consumed result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_f", 32'(f), 32'(e.f));
        chk("sb_cout", 32'(cout), 32'(e.c));
        chk("sb_zero", 32'(zero), 32'(e.z));
        chk("sb_ovf", 32'(ovf), 32'(e.v));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_flags", {29'd0, cout, zero, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: ADD wraps to zero, latency 1
    issue(0, 4'b1111, 4'b0001, 0, 1'b1);
    @(negedge clk);
    chk("add_wrap_valid", 32'(out_valid), 32'd1);
    chk("add_wrap_f", 32'(f), 32'b0000);
    chk("add_wrap_flags", {29'd0, cout, zero, ovf}, 32'b110);

    // 2: signed overflow on ADD, SUB with no borrow
    @(posedge clk);
    #1;
    issue(0, 4'b0111, 4'b0001, 0, 1'b1);
    @(negedge clk);
    chk("add_ovf_f", 32'(f), 32'b1000);
    chk("add_ovf_ovf", 32'(ovf), 32'd1);
    @(posedge clk);
    #1;
    issue(1, 4'b0101, 4'b0011, 1, 1'b1);
    @(negedge clk);
    chk("sub_f", 32'(f), 32'b0010);
    chk("sub_cout_ovf", {30'd0, cout, ovf}, 32'b10);

    // 3: SHL then SHR back-to-back, one result per cycle
    @(posedge clk);
    #1;
    issue(5, 4'b1001, 0, 1, 1'b1);
    fork
      issue(6, 4'b1001, 0, 0, 1'b1);
      begin
        @(negedge clk);
        chk("shl_f", 32'(f), 32'b0011);
        chk("shl_cout", 32'(cout), 32'd1);
      end
    join
    chk("b2b_accept_spacing", 32'(last_acc - prev_acc), 32'd1);
    @(negedge clk);
    chk("shr_valid", 32'(out_valid), 32'd1);
    chk("shr_f", 32'(f), 32'b0100);
    chk("shr_cout", 32'(cout), 32'd1);

    // 4: MUL timing and results
    @(posedge clk);
    #1;
    issue(7, 4'b1111, 4'b1111, 0, 1'b1);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
      chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_ff_f", 32'(f), 32'b0001);
    chk("mul_ff_cout", 32'(cout), 32'd1);
    @(posedge clk);
    #1;
    issue(7, 4'b0011, 4'b0010, 0, 1'b1);
    repeat (W + 1) @(negedge clk);
    chk("mul_32_valid", 32'(out_valid), 32'd1);
    chk("mul_32_f", 32'(f), 32'b0110);
    chk("mul_32_cout", 32'(cout), 32'd0);

    // 5: output hold under backpressure, then consume + accept on one edge
    @(posedge clk);
    #1;
    force_rdy = 1'b0;
    issue(2, 4'b1100, 4'b1010, 0, 1'b1);
    op = 3'b000;
    a = 4'b0001;
    b = 4'b0001;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_f", 32'(f), 32'b1000);
      chk("hold_flags", {29'd0, cout, zero, ovf}, 32'd0);
    end
    @(posedge clk);
    #1;
    force_rdy = 1'b1;
    issue(0, 4'b0001, 4'b0001, 0, 1'b1);
    chk("hold_release_accept_now", 32'(last_acc - prev_acc), 32'd4);
    @(negedge clk);
    chk("after_hold_valid", 32'(out_valid), 32'd1);
    chk("after_hold_f", 32'(f), 32'b0010);

    // 6: reset in the middle of a MUL discards it
    @(posedge clk);
    #1;
    issue(7, 4'b0101, 4'b0011, 0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_f", 32'(f), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_no_result", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    issue(0, 4'b0010, 4'b0011, 0, 1'b1);
    @(negedge clk);
    chk("postrst_add_f", 32'(f), 32'b0101);

    // Randomized traffic with random backpressure
    @(posedge clk);
    #1;
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b1);
    end
    rand_en = 1'b0;
    force_rdy = 1'b1;
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
